// File: rtl/sagu_miss_sched_pkg.sv
// Shared types and widths for the store-AGU TLB-miss recovery scheduler.
package sagu_miss_sched_pkg;
  localparam int VADDR_WIDTH = 44;
  localparam int ATTR_WIDTH  = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WREQ,
    S_WWAIT,
    S_REPLAY,
    S_CHECK1,
    S_CHECK2,
    S_DRAIN
  } state_t;
endpackage

// File: rtl/sagu_miss_sched_rr_arbiter_n.sv
// Combinational round-robin pick: first requesting index at or after ptr, wrapping.
module rr_arbiter_n #(
  parameter int N  = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);
  always_comb begin
    int j;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end
endmodule

// File: rtl/sagu_miss_sched.sv
// Latches per-AGU TLB misses, walks them one at a time round-robin, replays the
// translated address into the owning AGU and reports done/fault per miss.
module sagu_miss_sched
  import sagu_miss_sched_pkg::*;
#(
  parameter int N_AGU     = 3,
  parameter int MAX_RETRY = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         except,
  input  logic [N_AGU-1:0]             miss_req,
  input  logic [N_AGU*VADDR_WIDTH-1:0] miss_addr,
  input  logic [N_AGU*ATTR_WIDTH-1:0]  miss_attr,
  input  logic [N_AGU-1:0]             agu_tlb_hit,
  output logic                         walk_req,
  output logic [VADDR_WIDTH-1:0]       walk_addr,
  output logic [ATTR_WIDTH-1:0]        walk_attr,
  input  logic                         walk_ack,
  input  logic                         walk_done,
  input  logic                         walk_fault,
  output logic [N_AGU-1:0]             mex_en,
  output logic [VADDR_WIDTH-1:0]       mex_addr,
  output logic [ATTR_WIDTH-1:0]        mex_attr,
  output logic [N_AGU-1:0]             agu_stall,
  output logic [N_AGU-1:0]             miss_done,
  output logic [N_AGU-1:0]             miss_fault
);
  localparam int IW = (N_AGU > 1) ? $clog2(N_AGU) : 1;
  localparam int RW = (MAX_RETRY > 1) ? $clog2(MAX_RETRY) : 1;

  state_t                 state;
  logic [N_AGU-1:0]       pending;
  logic [N_AGU-1:0]       owner_oh;
  logic [IW-1:0]          owner;
  logic [IW-1:0]          rr_ptr;
  logic [RW-1:0]          retry;
  logic [VADDR_WIDTH-1:0] cap_addr [N_AGU];
  logic [ATTR_WIDTH-1:0]  cap_attr [N_AGU];

  logic             owner_active, chk_hit, can_retry, clr_owner;
  logic [N_AGU-1:0] arb_req, cap_en, gnt;
  logic [IW-1:0]    gnt_idx, ptr_nxt;
  logic             gnt_any;

  assign owner_active = (state == S_WREQ)   || (state == S_WWAIT)  ||
                        (state == S_REPLAY) || (state == S_CHECK1) ||
                        (state == S_CHECK2);
  assign chk_hit   = agu_tlb_hit[owner];
  assign can_retry = (int'(retry) < MAX_RETRY - 1);
  assign clr_owner = ((state == S_WWAIT) && walk_done && walk_fault) ||
                     ((state == S_CHECK2) && (chk_hit || !can_retry));

  // Arbitrate on incoming requests too, so walk_req follows miss_req by one cycle.
  assign arb_req = except ? '0 : (pending | miss_req);
  // The owner's capture is frozen while its walk is in flight, unless this cycle retires it.
  assign cap_en  = except ? '0 :
                   (miss_req & ~((owner_active && !clr_owner) ? owner_oh : '0));
  assign ptr_nxt = (int'(gnt_idx) == N_AGU - 1) ? '0 : gnt_idx + 1'b1;

  rr_arbiter_n #(.N(N_AGU), .IW(IW)) u_arb (
    .req (arb_req),
    .ptr (rr_ptr),
    .gnt (gnt),
    .idx (gnt_idx),
    .any (gnt_any)
  );

  assign agu_stall = pending;
  assign walk_addr = cap_addr[owner];
  assign walk_attr = cap_attr[owner];
  assign mex_addr  = cap_addr[owner];
  assign mex_attr  = cap_attr[owner];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending <= '0;
      for (int i = 0; i < N_AGU; i++) begin
        cap_addr[i] <= '0;
        cap_attr[i] <= '0;
      end
    end else begin
      if (except) pending <= '0;
      else        pending <= (pending & ~(clr_owner ? owner_oh : '0)) | miss_req;
      for (int i = 0; i < N_AGU; i++) begin
        if (cap_en[i]) begin
          cap_addr[i] <= miss_addr[i*VADDR_WIDTH +: VADDR_WIDTH];
          cap_attr[i] <= miss_attr[i*ATTR_WIDTH +: ATTR_WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      owner      <= '0;
      owner_oh   <= '0;
      rr_ptr     <= '0;
      retry      <= '0;
      walk_req   <= 1'b0;
      mex_en     <= '0;
      miss_done  <= '0;
      miss_fault <= '0;
    end else begin
      mex_en     <= '0;
      miss_done  <= '0;
      miss_fault <= '0;
      if (except) retry <= '0;
      case (state)
        S_IDLE: if (gnt_any) begin
          owner    <= gnt_idx;
          owner_oh <= gnt;
          rr_ptr   <= ptr_nxt;
          walk_req <= 1'b1;
          state    <= S_WREQ;
        end
        S_WREQ: begin
          if (except) begin
            walk_req <= 1'b0;
            // An accepted walk cannot be withdrawn; wait out its completion.
            state    <= walk_ack ? S_DRAIN : S_IDLE;
          end else if (walk_ack) begin
            walk_req <= 1'b0;
            state    <= S_WWAIT;
          end
        end
        S_WWAIT: begin
          if (except) begin
            state <= walk_done ? S_IDLE : S_DRAIN;
          end else if (walk_done && walk_fault) begin
            miss_fault <= owner_oh;
            retry      <= '0;
            state      <= S_IDLE;
          end else if (walk_done) begin
            mex_en <= owner_oh;
            state  <= S_REPLAY;
          end
        end
        S_REPLAY: state <= except ? S_IDLE : S_CHECK1;
        S_CHECK1: state <= except ? S_IDLE : S_CHECK2;
        S_CHECK2: begin
          if (except) begin
            state <= S_IDLE;
          end else if (chk_hit) begin
            miss_done <= owner_oh;
            retry     <= '0;
            state     <= S_IDLE;
          end else if (can_retry) begin
            retry    <= retry + 1'b1;
            walk_req <= 1'b1;
            state    <= S_WREQ;
          end else begin
            miss_fault <= owner_oh;
            retry      <= '0;
            state      <= S_IDLE;
          end
        end
        S_DRAIN: if (walk_done) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sagu_miss_sched.sv
// Scoreboard bench for sagu_miss_sched: directed misses, expected walker/replay/done/fault events queued.
`timescale 1ns/1ps
module tb_sagu_miss_sched;
  localparam int N  = 3;
  localparam int AW = 44;
  localparam int TW = 4;
  localparam logic [1:0] K_WALK = 2'd0, K_MEX = 2'd1, K_DONE = 2'd2, K_FAULT = 2'd3;

  typedef struct packed {
    logic [1:0]    kind;
    logic [N-1:0]  vec;
    logic [AW-1:0] addr;
    logic [TW-1:0] attr;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          except = 1'b0;
  logic [N-1:0]  miss_req = '0;
  logic [N*AW-1:0] miss_addr = '0;
  logic [N*TW-1:0] miss_attr = '0;
  logic [N-1:0]  agu_tlb_hit = '0;
  logic          walk_req;
  logic [AW-1:0] walk_addr;
  logic [TW-1:0] walk_attr;
  logic          walk_ack = 1'b0;
  logic          walk_done = 1'b0;
  logic          walk_fault = 1'b0;
  logic [N-1:0]  mex_en;
  logic [AW-1:0] mex_addr;
  logic [TW-1:0] mex_attr;
  logic [N-1:0]  agu_stall;
  logic [N-1:0]  miss_done;
  logic [N-1:0]  miss_fault;

  int  vectors = 0;
  int  miscompares = 0;
  ev_t exp_q[$];

  sagu_miss_sched #(.N_AGU(N), .MAX_RETRY(2)) dut (
    .clk(clk), .rst(rst), .except(except),
    .miss_req(miss_req), .miss_addr(miss_addr), .miss_attr(miss_attr),
    .agu_tlb_hit(agu_tlb_hit),
    .walk_req(walk_req), .walk_addr(walk_addr), .walk_attr(walk_attr),
    .walk_ack(walk_ack), .walk_done(walk_done), .walk_fault(walk_fault),
    .mex_en(mex_en), .mex_addr(mex_addr), .mex_attr(mex_attr),
    .agu_stall(agu_stall), .miss_done(miss_done), .miss_fault(miss_fault)
  );

  always #5 clk = ~clk;

  function automatic ev_t mk(input logic [1:0] k, input logic [N-1:0] v,
                             input logic [AW-1:0] a, input logic [TW-1:0] t);
    ev_t r;
    r.kind = k; r.vec = v; r.addr = a; r.attr = t;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic got(input ev_t e);
    ev_t x;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL unexpected_event: got kind=%0d vec=%b addr=%h attr=%h, expected none",
               e.kind, e.vec, e.addr, e.attr);
    end else begin
      x = exp_q.pop_front();
      if (e !== x) begin
        miscompares++;
        $display("FAIL event: got kind=%0d vec=%b addr=%h attr=%h, expected kind=%0d vec=%b addr=%h attr=%h",
                 e.kind, e.vec, e.addr, e.attr, x.kind, x.vec, x.addr, x.attr);
      end
    end
  endtask

  // Monitor: every observable response is matched against the scoreboard queue.
  always @(negedge clk) begin
    if (rst) begin
      if (walk_req && walk_ack) got(mk(K_WALK, '0, walk_addr, walk_attr));
      if (mex_en != '0)         got(mk(K_MEX, mex_en, mex_addr, mex_attr));
      if (miss_done != '0)      got(mk(K_DONE, miss_done, '0, '0));
      if (miss_fault != '0)     got(mk(K_FAULT, miss_fault, '0, '0));
      if ((mex_en | miss_done | miss_fault) != '0)
        chk("pulse_excl", 64'((mex_en & miss_done) | (mex_en & miss_fault) | (miss_done & miss_fault)), 64'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_miss(input int i, input logic [AW-1:0] a, input logic [TW-1:0] t);
    miss_req[i] = 1'b1;
    miss_addr[i*AW +: AW] = a;
    miss_attr[i*TW +: TW] = t;
  endtask

  task automatic do_reset();
    rst = 1'b0; except = 1'b0; miss_req = '0;
    walk_ack = 1'b0; walk_done = 1'b0; walk_fault = 1'b0;
    tick(); tick();
    chk("rst_walk_req",  64'(walk_req),  64'd0);
    chk("rst_walk_addr", 64'(walk_addr), 64'd0);
    chk("rst_walk_attr", 64'(walk_attr), 64'd0);
    chk("rst_mex_en",    64'(mex_en),    64'd0);
    chk("rst_mex_addr",  64'(mex_addr),  64'd0);
    chk("rst_stall",     64'(agu_stall), 64'd0);
    chk("rst_done",      64'(miss_done), 64'd0);
    chk("rst_fault",     64'(miss_fault), 64'd0);
    rst = 1'b1;
  endtask

  task automatic do_walk(input int lat, input logic flt);
    int n;
    n = 0;
    while (!walk_req && n < 50) begin tick(); n++; end
    if (!walk_req) begin
      chk("walk_req_timeout", 64'(walk_req), 64'd1);
      return;
    end
    walk_ack = 1'b1; tick(); walk_ack = 1'b0;
    repeat (lat - 1) tick();
    walk_done = 1'b1; walk_fault = flt; tick();
    walk_done = 1'b0; walk_fault = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    // Single miss with clean walk and TLB hit on replay
    do_reset();
    agu_tlb_hit = 3'b010;
    exp_q.push_back(mk(K_WALK, '0, 44'h123_4567_8000, 4'h5));
    exp_q.push_back(mk(K_MEX, 3'b010, 44'h123_4567_8000, 4'h5));
    exp_q.push_back(mk(K_DONE, 3'b010, '0, '0));
    set_miss(1, 44'h123_4567_8000, 4'h5); tick(); miss_req = '0;
    chk("t1_walk_req_lat", 64'(walk_req),  64'd1);
    chk("t1_walk_addr",    64'(walk_addr), 64'h123_4567_8000);
    chk("t1_stall_set",    64'(agu_stall), 64'b010);
    do_walk(3, 1'b0);
    repeat (6) tick();
    chk("t1_stall_clr", 64'(agu_stall), 64'd0);
    chk("t1_q_empty",   64'(exp_q.size()), 64'd0);

    // Round-robin 0,1,2 then a late request from AGU 0
    do_reset();
    agu_tlb_hit = 3'b111;
    exp_q.push_back(mk(K_WALK, '0, 44'h0AA_0000_1000, 4'h1));
    exp_q.push_back(mk(K_MEX, 3'b001, 44'h0AA_0000_1000, 4'h1));
    exp_q.push_back(mk(K_DONE, 3'b001, '0, '0));
    exp_q.push_back(mk(K_WALK, '0, 44'h0BB_0000_2000, 4'h2));
    exp_q.push_back(mk(K_MEX, 3'b010, 44'h0BB_0000_2000, 4'h2));
    exp_q.push_back(mk(K_DONE, 3'b010, '0, '0));
    exp_q.push_back(mk(K_WALK, '0, 44'h0CC_0000_3000, 4'h3));
    exp_q.push_back(mk(K_MEX, 3'b100, 44'h0CC_0000_3000, 4'h3));
    exp_q.push_back(mk(K_DONE, 3'b100, '0, '0));
    exp_q.push_back(mk(K_WALK, '0, 44'h0DD_0000_4000, 4'h4));
    exp_q.push_back(mk(K_MEX, 3'b001, 44'h0DD_0000_4000, 4'h4));
    exp_q.push_back(mk(K_DONE, 3'b001, '0, '0));
    set_miss(0, 44'h0AA_0000_1000, 4'h1);
    set_miss(1, 44'h0BB_0000_2000, 4'h2);
    set_miss(2, 44'h0CC_0000_3000, 4'h3);
    tick(); miss_req = '0;
    chk("t2_stall_all", 64'(agu_stall), 64'b111);
    do_walk(2, 1'b0);
    do_walk(2, 1'b0);
    set_miss(0, 44'h0DD_0000_4000, 4'h4); tick(); miss_req = '0;
    do_walk(2, 1'b0);
    do_walk(2, 1'b0);
    repeat (6) tick();
    chk("t2_stall_clr", 64'(agu_stall), 64'd0);
    chk("t2_q_empty",   64'(exp_q.size()), 64'd0);

    // Retry exhaustion: two walks, then fault
    do_reset();
    agu_tlb_hit = 3'b000;
    exp_q.push_back(mk(K_WALK, '0, 44'h777_0000_0040, 4'h9));
    exp_q.push_back(mk(K_MEX, 3'b100, 44'h777_0000_0040, 4'h9));
    exp_q.push_back(mk(K_WALK, '0, 44'h777_0000_0040, 4'h9));
    exp_q.push_back(mk(K_MEX, 3'b100, 44'h777_0000_0040, 4'h9));
    exp_q.push_back(mk(K_FAULT, 3'b100, '0, '0));
    set_miss(2, 44'h777_0000_0040, 4'h9); tick(); miss_req = '0;
    do_walk(2, 1'b0);
    do_walk(2, 1'b0);
    repeat (6) tick();
    chk("t3_stall_clr", 64'(agu_stall), 64'd0);
    chk("t3_q_empty",   64'(exp_q.size()), 64'd0);

    // Walk fault: fault pulse the cycle after walk_done, no replay
    do_reset();
    agu_tlb_hit = 3'b111;
    exp_q.push_back(mk(K_WALK, '0, 44'h0E0_1234_5000, 4'hA));
    exp_q.push_back(mk(K_FAULT, 3'b001, '0, '0));
    set_miss(0, 44'h0E0_1234_5000, 4'hA); tick(); miss_req = '0;
    do_walk(2, 1'b1);
    chk("t4_fault_now", 64'(miss_fault), 64'b001);
    chk("t4_no_mex",    64'(mex_en),     64'd0);
    chk("t4_stall_clr", 64'(agu_stall),  64'd0);
    repeat (4) tick();
    chk("t4_idle_no_walk", 64'(walk_req), 64'd0);
    chk("t4_q_empty", 64'(exp_q.size()), 64'd0);

    // Flush while waiting on the walker, then a request latched during drain
    do_reset();
    agu_tlb_hit = 3'b110;
    exp_q.push_back(mk(K_WALK, '0, 44'h0F0_0000_6000, 4'h6));
    exp_q.push_back(mk(K_WALK, '0, 44'h0A5_0000_7000, 4'h7));
    exp_q.push_back(mk(K_MEX, 3'b100, 44'h0A5_0000_7000, 4'h7));
    exp_q.push_back(mk(K_DONE, 3'b100, '0, '0));
    set_miss(1, 44'h0F0_0000_6000, 4'h6); tick(); miss_req = '0;
    walk_ack = 1'b1; tick(); walk_ack = 1'b0;
    except = 1'b1; tick(); except = 1'b0;
    chk("t5_flush_stall", 64'(agu_stall), 64'd0);
    set_miss(2, 44'h0A5_0000_7000, 4'h7); tick(); miss_req = '0;
    chk("t5_drain_latch", 64'(agu_stall), 64'b100);
    chk("t5_drain_nogrant", 64'(walk_req), 64'd0);
    tick();
    walk_done = 1'b1; tick(); walk_done = 1'b0;
    chk("t5_after_drain_walk", 64'(walk_req), 64'd0);
    do_walk(2, 1'b0);
    repeat (6) tick();
    chk("t5_q_empty", 64'(exp_q.size()), 64'd0);

    // Asynchronous reset during replay
    do_reset();
    agu_tlb_hit = 3'b001;
    exp_q.push_back(mk(K_WALK, '0, 44'h0B0_0000_8000, 4'h8));
    set_miss(0, 44'h0B0_0000_8000, 4'h8); tick(); miss_req = '0;
    do_walk(2, 1'b0);
    chk("t6_in_replay", 64'(mex_en), 64'b001);
    #2 rst = 1'b0;
    #1;
    chk("t6_async_mex",   64'(mex_en),    64'd0);
    chk("t6_async_walk",  64'(walk_req),  64'd0);
    chk("t6_async_stall", 64'(agu_stall), 64'd0);
    tick(); tick();
    rst = 1'b1;
    repeat (5) tick();
    chk("t6_idle_walk",  64'(walk_req),  64'd0);
    chk("t6_idle_stall", 64'(agu_stall), 64'd0);
    chk("t6_q_empty",    64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
